// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: serializes command frames onto TX_OUT and collects
// response bytes from RX_IN. Define UART_CMD_HOST_TIMEOUT_EN to add the response timeout.
module uart_cmd_host #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        par_en,
  input  logic        par_typ,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_fun,
  output logic        TX_OUT,
  input  logic        RX_IN,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
`ifdef UART_CMD_HOST_TIMEOUT_EN
  output logic        rsp_timeout,
`endif
  output logic        busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned SW = $clog2(GAP_BITS + 12);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {M_IDLE, M_SEND, M_WAIT, M_DONE} m_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA} r_state_t;

  m_state_t m_state, m_next;
  r_state_t r_state, r_next;

  logic [1:0]    type_q;
  logic [3:0]    addr_q, fun_q;
  logic [7:0]    a_q, b_q;
  logic          par_q, odd_q;
  logic [CW-1:0] tx_cnt;
  logic [SW-1:0] slot, slot_nx, slot_last;
  logic [1:0]    byte_idx, last_idx, rsp_need;
  logic [7:0]    cur_byte;
  logic [10:0]   frame;
  logic          bit_nx, accept, tx_bit_end, tx_slot_end, tx_last_byte;

  logic          rx_s1, rx_s2, rx_s3, rx_fall;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx, rx_last;
  logic [7:0]    rx_sh;
  logic          rx_perr, rx_done, take;
  logic [1:0]    rcv_cnt;
  logic [7:0]    rsp_lo, rsp_hi;
  logic          err_acc, timeout_hit, to_fire;

  assign accept = cmd_valid & cmd_ready;

  // Per-command byte count and expected response length
  always_comb begin
    case (type_q)
      2'd0:    begin last_idx = 2'd2; rsp_need = 2'd0; end
      2'd1:    begin last_idx = 2'd1; rsp_need = 2'd1; end
      2'd2:    begin last_idx = 2'd3; rsp_need = 2'd2; end
      default: begin last_idx = 2'd1; rsp_need = 2'd2; end
    endcase
  end

  // Byte currently on the wire
  always_comb begin
    cur_byte = {4'h0, fun_q};
    if (byte_idx == 2'd0) begin
      case (type_q)
        2'd0:    cur_byte = 8'hAA;
        2'd1:    cur_byte = 8'hBB;
        2'd2:    cur_byte = 8'hCC;
        default: cur_byte = 8'hDD;
      endcase
    end else begin
      case (type_q)
        2'd0:    cur_byte = (byte_idx == 2'd1) ? {4'h0, addr_q} : a_q;
        2'd1:    cur_byte = {4'h0, addr_q};
        2'd2:    cur_byte = (byte_idx == 2'd1) ? a_q :
                            (byte_idx == 2'd2) ? b_q : {4'h0, fun_q};
        default: cur_byte = {4'h0, fun_q};
      endcase
    end
  end

  // Slots past the stop bit (and the parity slot when disabled) idle high
  assign frame        = {1'b1, par_q ? (^cur_byte ^ odd_q) : 1'b1, cur_byte, 1'b0};
  assign slot_nx      = slot + SW'(1);
  assign bit_nx       = (slot_nx < SW'(11)) ? frame[slot_nx[3:0]] : 1'b1;
  assign slot_last    = par_q ? SW'(10 + GAP_BITS) : SW'(9 + GAP_BITS);
  assign tx_bit_end   = (tx_cnt == BIT_END);
  assign tx_slot_end  = tx_bit_end && (slot == slot_last);
  assign tx_last_byte = (byte_idx == last_idx);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) m_state <= M_IDLE;
    else      m_state <= m_next;
  end

  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE: if (accept) m_next = M_SEND;
      M_SEND: if (tx_slot_end && tx_last_byte) m_next = (rsp_need == 2'd0) ? M_DONE : M_WAIT;
      M_WAIT: if (rcv_cnt >= rsp_need || timeout_hit) m_next = M_DONE;
      default: m_next = M_IDLE;
    endcase
  end

  // Command latch and TX serializer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT   <= 1'b1;
      tx_cnt   <= '0;
      slot     <= '0;
      byte_idx <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      fun_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      par_q    <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          TX_OUT <= 1'b1;
          if (accept) begin
            type_q   <= cmd_type;
            addr_q   <= cmd_addr;
            fun_q    <= cmd_fun;
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            par_q    <= par_en;
            odd_q    <= par_typ;
            tx_cnt   <= '0;
            slot     <= '0;
            byte_idx <= '0;
            TX_OUT   <= 1'b0;
          end
        end
        M_SEND: begin
          if (!tx_bit_end) begin
            tx_cnt <= tx_cnt + CW'(1);
          end else begin
            tx_cnt <= '0;
            if (slot != slot_last) begin
              slot   <= slot_nx;
              TX_OUT <= bit_nx;
            end else begin
              slot <= '0;
              if (!tx_last_byte) begin
                byte_idx <= byte_idx + 2'd1;
                TX_OUT   <= 1'b0;
              end
            end
          end
        end
        default: TX_OUT <= 1'b1;
      endcase
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_last = par_q ? 4'd9 : 4'd8;
  assign rx_done = (r_state == R_DATA) && (rx_cnt == BIT_END) && (rx_idx == rx_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rx_fall) r_next = R_START;
      R_START: if (rx_cnt == BIT_MID) r_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RX synchronizer and mid-bit sampler
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_perr <= 1'b0;
    end else begin
      rx_s1 <= RX_IN;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (r_state)
        R_IDLE: rx_cnt <= '0;
        R_START: begin
          rx_idx  <= '0;
          rx_perr <= 1'b0;
          rx_cnt  <= (rx_cnt == BIT_MID) ? '0 : rx_cnt + CW'(1);
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx < 4'd8)
              rx_sh <= {rx_s2, rx_sh[7:1]};
            else if (rx_idx == 4'd8 && par_q)
              rx_perr <= (rx_s2 != (^rx_sh ^ odd_q));
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Bytes count only once the command can own a response
  assign take = rx_done && (rcv_cnt != 2'd2) &&
                ((m_state == M_WAIT) || (m_state == M_SEND && type_q != 2'd0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rcv_cnt <= '0;
      rsp_lo  <= '0;
      rsp_hi  <= '0;
      err_acc <= 1'b0;
    end else if (accept) begin
      rcv_cnt <= '0;
      rsp_lo  <= '0;
      rsp_hi  <= '0;
      err_acc <= 1'b0;
    end else if (take) begin
      if (rcv_cnt == 2'd0) rsp_lo <= rx_sh;
      else                 rsp_hi <= rx_sh;
      rcv_cnt <= rcv_cnt + 2'd1;
      err_acc <= err_acc | rx_perr | ~rx_s2;
    end
  end

`ifdef UART_CMD_HOST_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = 16 * 11 * CLKS_PER_BIT;
  logic [15:0] to_cnt;
  logic        rx_start;

  assign rx_start = (r_state == R_START) && (rx_cnt == BIT_MID) && !rx_s2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                              to_cnt <= '0;
    else if (m_state != M_WAIT || rx_start) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 16'd1;
  end

  assign timeout_hit = (m_state == M_WAIT) && (to_cnt == 16'(TO_LIMIT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign to_fire = (m_state == M_WAIT) && timeout_hit && (rcv_cnt < rsp_need);

  // Registered handshake and response outputs, derived from the next state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
`ifdef UART_CMD_HOST_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      cmd_ready <= (m_next == M_IDLE);
      busy      <= (m_next == M_SEND) || (m_next == M_WAIT);
      rsp_valid <= (m_next == M_DONE);
`ifdef UART_CMD_HOST_TIMEOUT_EN
      rsp_timeout <= (m_next == M_DONE) && to_fire;
`endif
      if (m_next == M_DONE) begin
        rsp_data <= {rsp_hi, rsp_lo};
        rsp_err  <= err_acc | to_fire;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host: directed and random commands checked against a frame-level
// model of the serial line and the expected response.
module tb_uart_cmd_host;

  localparam int CPB = 8;
  localparam int GAP = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic        TX_OUT;
  logic        RX_IN = 1'b1;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
`ifdef UART_CMD_HOST_TIMEOUT_EN
  logic        rsp_timeout;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_tx[$];
  logic       wave[$];

  uart_cmd_host #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_typ(par_typ),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .TX_OUT(TX_OUT), .RX_IN(RX_IN), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
`ifdef UART_CMD_HOST_TIMEOUT_EN
    .rsp_timeout(rsp_timeout),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rsp_count(input logic [1:0] t);
    return (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  task automatic build_tx(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] f);
    exp_tx.delete();
    case (t)
      2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, ad}); exp_tx.push_back(a); end
      2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, ad}); end
      2'd2: begin
        exp_tx.push_back(8'hCC); exp_tx.push_back(a); exp_tx.push_back(b);
        exp_tx.push_back({4'h0, f});
      end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, f}); end
    endcase
  endtask

  // Expected line level for every clock cycle from the cycle after accept
  task automatic build_wave(input logic pe, input logic pt);
    logic bits[$];
    wave.delete();
    foreach (exp_tx[i]) begin
      bits.delete();
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(exp_tx[i][3'(j)]);
      if (pe) bits.push_back(par_bit(exp_tx[i], pt));
      bits.push_back(1'b1);
      for (int g = 0; g < GAP; g++) bits.push_back(1'b1);
      foreach (bits[j]) repeat (CPB) wave.push_back(bits[j]);
    end
  endtask

  // err: 0 clean, 1 stop bit low, 2 parity bit inverted
  task automatic rx_send(input logic [7:0] d, input logic pe, input logic pt, input int err);
    logic bits[$];
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(d[3'(j)]);
    if (pe) bits.push_back(par_bit(d, pt) ^ (err == 2));
    bits.push_back(err != 1);
    bits.push_back(1'b1);
    bits.push_back(1'b1);
    foreach (bits[j]) begin
      RX_IN = bits[j];
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] t, input logic [3:0] ad,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                        input logic pe, input logic pt, input logic [7:0] r0,
                        input logic [7:0] r1, input int e0, input int e1, input logic glitch);
    int nrsp, bad, early, n;
    logic got, v2, rdy2, gerr, gbusy, exp_err;
    logic [15:0] gdata, exp_data;
    nrsp = rsp_count(t);
    build_tx(t, ad, a, b, f);
    build_wave(pe, pt);
    exp_data = (nrsp == 0) ? 16'h0000 : (nrsp == 1) ? {8'h00, r0} : {r1, r0};
    exp_err  = (nrsp >= 1 && (e0 == 1 || (e0 == 2 && pe))) ||
               (nrsp == 2 && (e1 == 1 || (e1 == 2 && pe)));
    @(negedge CLK);
    check({tag, " ready before accept"}, 32'(cmd_ready), 32'd1);
    cmd_type = t; cmd_addr = ad; cmd_a = a; cmd_b = b; cmd_fun = f;
    par_en = pe; par_typ = pt; cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    par_en  = 1'($urandom);
    par_typ = 1'($urandom);
    cmd_a   = 8'($urandom);
    bad = 0;
    early = 0;
    foreach (wave[k]) begin
      @(negedge CLK);
      if (TX_OUT !== wave[k]) bad++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) early++;
    end
    check({tag, " tx line cycles wrong"}, 32'(bad), 32'd0);
    check({tag, " ctrl cycles wrong during send"}, 32'(early), 32'd0);
    got = 1'b0; gdata = '0; gerr = 1'b0; gbusy = 1'b1; v2 = 1'b1; rdy2 = 1'b0;
    if (nrsp == 0) begin
      @(negedge CLK);
      got = rsp_valid; gdata = rsp_data; gerr = rsp_err; gbusy = busy;
      @(negedge CLK);
      v2 = rsp_valid; rdy2 = cmd_ready;
    end else begin
      fork
        begin
          if (glitch) begin
            RX_IN = 1'b0;
            repeat (2) @(negedge CLK);
            RX_IN = 1'b1;
            repeat (2 * CPB) @(negedge CLK);
          end
          rx_send(r0, pe, pt, e0);
          if (nrsp == 2) rx_send(r1, pe, pt, e1);
        end
        begin
          n = 0;
          while (!got && n < 60 * CPB) begin
            @(negedge CLK);
            n++;
            if (rsp_valid === 1'b1) begin
              got = 1'b1; gdata = rsp_data; gerr = rsp_err; gbusy = busy;
            end
          end
          if (got) begin
            @(negedge CLK);
            v2 = rsp_valid; rdy2 = cmd_ready;
          end
        end
      join
    end
    check({tag, " rsp_valid seen"}, 32'(got), 32'd1);
    check({tag, " rsp_data"}, 32'(gdata), 32'(exp_data));
    check({tag, " rsp_err"}, 32'(gerr), 32'(exp_err));
    check({tag, " busy at done"}, 32'(gbusy), 32'd0);
    check({tag, " rsp_valid one cycle"}, 32'(v2), 32'd0);
    check({tag, " ready after done"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    int viol;
    logic [1:0] rt;
    #1 RST = 1'b0;
    #2;
    check("reset TX_OUT", 32'(TX_OUT), 32'd1);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", 32'(rsp_data), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    viol = 0;
    repeat (4) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) viol++;
    end
    check("held in reset", 32'(viol), 32'd0);
    RST = 1'b1;

    do_cmd("t0 write", 2'd0, 4'h4, 8'h5A, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
    do_cmd("t1 read", 2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h3C, 8'h00, 0, 0, 1'b0);
    do_cmd("t2 alu", 2'd2, 4'h0, 8'h10, 8'h20, 4'h0, 1'b0, 1'b0, 8'h30, 8'h00, 0, 0, 1'b0);
    do_cmd("t3 bad stop", 2'd3, 4'h0, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0, 8'h55, 8'h12, 1, 0, 1'b0);
    do_cmd("t1 glitch", 2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'hA5, 8'h00, 0, 0, 1'b1);
    do_cmd("t3 bad parity", 2'd3, 4'h0, 8'h00, 8'h00, 4'h9, 1'b1, 1'b1, 8'h0F, 8'hE1, 0, 2, 1'b0);

    // A byte arriving while idle must not produce a response
    viol = 0;
    @(negedge CLK);
    fork
      rx_send(8'h77, 1'b0, 1'b0, 0);
      repeat (13 * CPB) begin
        @(negedge CLK);
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) viol++;
      end
    join
    check("idle byte discarded", 32'(viol), 32'd0);

    // Reset in the middle of a type 2 frame
    @(negedge CLK);
    cmd_type = 2'd2; cmd_a = 8'h10; cmd_b = 8'h20; cmd_fun = 4'h0;
    par_en = 1'b0; par_typ = 1'b0; cmd_valid = 1'b1;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    repeat (42) @(negedge CLK);
    check("pre-reset tx low", 32'(TX_OUT), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("mid reset TX_OUT", 32'(TX_OUT), 32'd1);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    viol = 0;
    repeat (3) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0 || TX_OUT !== 1'b1) viol++;
    end
    check("mid reset quiet", 32'(viol), 32'd0);
    RST = 1'b1;
    do_cmd("post reset t1", 2'd1, 4'hB, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'hC3, 8'h00, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rt = 2'($urandom_range(0, 3));
      do_cmd($sformatf("rand%0d t%0d", i, rt), rt, 4'($urandom), 8'($urandom), 8'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
             1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
